display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexing scan controller for the 8-digit seven-segment display. It sits between the per-digit `binary_to_seven_seg` encoders and the board's `D0_AN`/`D0_SEG` pins. It replaces the free-running mux with a sequenced scanner that adds:
- a per-digit enable mask, with disabled digits skipped entirely;
- a blanking interval at each digit change to suppress ghosting;
- 16-level PWM brightness;
- a frame-tick output for upstream logic.

## Interface
Parameters:
- `PRESCALE`, 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ `BLANK` + 16.
- `BLANK`, 1000: dead cycles at the start of each slot, with all anodes off.
- Constraint: (`PRESCALE` − `BLANK`) must be a multiple of 16. The step size is STEP = (`PRESCALE` − `BLANK`)/16.

Ports:
- `clk` (in, 1): system clock.
- `rst_n` (in, 1): reset. One clock; reset is asynchronous and active-low.
- `seg_in` (in, 64): encoded segment patterns, active-low. Digit k occupies bits [8k+7:8k].
- `digit_en` (in, 8): per-digit enable; 1 means the digit is scanned.
- `bright` (in, 4): brightness level; on-time is (`bright`+1)/16 of the active window.
- `an` (out, 8): anode drive, active-low, one-hot-low or all ones.
- `sseg` (out, 8): segment drive, active-low.
- `digit_idx` (out, 3): index of the digit currently owning the slot.
- `frame_tick` (out, 1): single-cycle pulse when the scan wraps.

## Operation
- `slot_cnt` counts 0..`PRESCALE`−1 and wraps. The wrap cycle is the slot boundary.
- Per-slot phases, decoded from `slot_cnt`:
  - BLANK: `slot_cnt` < `BLANK`.
  - ON: `BLANK` ≤ `slot_cnt` < `BLANK` + STEP·(`bright_q`+1).
  - OFF: the remainder of the slot.
  - At `bright_q`=15 the OFF phase is empty. With `BLANK`=0 the BLANK phase is empty.
- `bright_q` is latched from `bright` at each slot boundary. Mid-slot changes to `bright` have no effect until the next slot.
- At a slot boundary, `digit_idx` advances to the next set bit of `digit_en`, searching idx+1, idx+2, … modulo 8.
  - If only the current digit is enabled, `digit_idx` stays.
  - If `digit_en`==0, `digit_idx` holds.
- `frame_tick` is asserted for the single cycle after a boundary at which the new index is ≤ the old index, including the case of the same index.
  - No pulse while `digit_en`==0.
- Output drive:
  - During ON, with `digit_en[digit_idx]`=1: `an` = ~(1<<`digit_idx`) and `sseg` = `seg_in[digit_idx]`. `seg_in` is sampled live every cycle.
  - In all other cases: `an`=8'hFF and `sseg`=8'hFF.
  - If the current digit's enable drops mid-slot, the digit blanks within 1 cycle and the scan advances at the next boundary.
- `an`, `sseg` and `frame_tick` are registered. `digit_idx` is a state register.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `slot_cnt`=0, `digit_idx`=0, `bright_q`=0.
  - `an`=8'hFF, `sseg`=8'hFF, `frame_tick`=0.
- The first slot after reset belongs to digit 0, regardless of `digit_en[0]`. If digit 0 is disabled, it stays dark, and the first advance happens at the first boundary.
- Output latency is 1 cycle. A phase or index change on edge N is visible on `an`/`sseg` after edge N+1.
- Slot boundary: `slot_cnt`=`PRESCALE`−1 at edge N. At edge N+1, `slot_cnt`=0 and the new `digit_idx` and `bright_q` take effect. `frame_tick` is high from edge N+1 to edge N+2.
- `digit_en` is sampled at the boundary edge for the advance search. Between boundaries it only gates the output.
- Reset mid-slot: all state returns to reset values. No partial-slot drive persists.
- Full scan period is n·`PRESCALE` cycles, where n = popcount(`digit_en`) ≥ 1. The period is constant as long as `digit_en` is stable.

## Test plan
Bench parameters: `PRESCALE`=36, `BLANK`=4, so STEP=2.

1. Reset sequencing.
   - Stimulus: hold `rst_n`=0, then release with `digit_en`=8'hFF and `bright`=15.
   - Response: `an`/`sseg`=FF during reset. After 5 cycles, `an`=8'hFE with `sseg`=`seg_in[7:0]`. `digit_idx` steps 0→1 at cycle 36, and `frame_tick` pulses once every 288 cycles.
2. Skip mask.
   - Stimulus: `digit_en`=8'b1000_0101.
   - Response: `digit_idx` sequence 0,2,7,0,… with 36 cycles each. `frame_tick` pulses every 108 cycles. `an` is never 8'hFD.
3. Brightness.
   - Stimulus: `bright`=0, then `bright`=7.
   - Response: `an` is low for 2 cycles per slot, then 16 cycles per slot.
   - Stimulus: change `bright` mid-slot.
   - Response: the duty changes only from the next slot.
4. Degenerate masks.
   - Stimulus: `digit_en`=8'h00.
   - Response: `an`=FF permanently, `digit_idx` frozen, no `frame_tick`.
   - Stimulus: `digit_en`=8'h10.
   - Response: `digit_idx` reaches 4 and stays. `frame_tick` pulses every 36 cycles.
5. Mid-slot disable and asynchronous reset.
   - Stimulus: clear the current digit's enable during ON.
   - Response: `an`=FF on the next output edge.
   - Stimulus: assert `rst_n`=0 mid-ON.
   - Response: `an`=FF immediately without a clock. After release, the scan restarts at digit 0 with `slot_cnt`=0.
6. Live data.
   - Stimulus: change `seg_in[7:0]` during digit 0's ON phase.
   - Response: `sseg` follows one cycle later.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Each enabled digit owns one slot of PRESCALE cycles. A slot starts with a
// blanking interval and continues with a PWM on-window sized by the latched
// brightness. Disabled digits are skipped. A frame tick marks each scan wrap.
// an/sseg/frame_tick are registered, so they show the state one cycle late.

module display_scan_ctrl #(
   parameter int PRESCALE = 100000,
   parameter int BLANK    = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] seg_in,
   input  logic [7:0]  digit_en,
   input  logic [3:0]  bright,
   output logic [7:0]  an,
   output logic [7:0]  sseg,
   output logic [2:0]  digit_idx,
   output logic        frame_tick
);

   // Counter width also holds PRESCALE itself, which is the largest on-window end.
   localparam int CW   = $clog2(PRESCALE + 1);
   localparam int STEP = (PRESCALE - BLANK) / 16;

   localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
   localparam logic [CW-1:0] STEP_C  = CW'(STEP);
   localparam logic [CW-1:0] LAST_C  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] ZERO_C  = CW'(0);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [CW-1:0] slot_cnt_r;
   logic [2:0]    digit_idx_r;
   logic [3:0]    bright_q_r;
   logic [7:0]    an_r;
   logic [7:0]    sseg_r;
   logic          frame_tick_r;

   logic          at_wrap_s;
   logic [4:0]    bright_plus1_s;
   logic [CW-1:0] on_end_s;
   logic          on_s;
   logic          drive_s;
   logic [2:0]    next_idx_s;
   logic          tick_s;
   logic [7:0]    an_next_s;
   logic [7:0]    sseg_next_s;

   // Slot phase decode: blanking first, then a STEP*(bright_q+1) on-window.
   always_comb begin
      at_wrap_s      = (slot_cnt_r == LAST_C);
      bright_plus1_s = {1'b0, bright_q_r} + 5'd1;
      on_end_s       = BLANK_C + (STEP_C * CW'(bright_plus1_s));
      on_s           = (slot_cnt_r >= BLANK_C) && (slot_cnt_r < on_end_s);
      drive_s        = on_s && digit_en[digit_idx_r];
   end

   // Next enabled digit after the current one, wrapping; offset 8 is the current
   // digit itself. Descending search so the nearest enabled digit wins; with no
   // digit enabled the index simply holds.
   always_comb begin
      next_idx_s = digit_idx_r;
      for (int k = 8; k >= 1; k--) begin
         next_idx_s = digit_en[digit_idx_r + 3'(k)] ? (digit_idx_r + 3'(k)) : next_idx_s;
      end
      tick_s = at_wrap_s && (digit_en != 8'h00) && (next_idx_s <= digit_idx_r);
   end

   // Output pattern for the current cycle; seg_in is taken live.
   always_comb begin
      if (drive_s) begin
         an_next_s   = ~(8'h01 << digit_idx_r);
         sseg_next_s = seg_in[{digit_idx_r, 3'b000} +: 8];
      end else begin
         an_next_s   = 8'hFF;
         sseg_next_s = 8'hFF;
      end
   end

   // Slot counter, digit index and brightness latch; index/brightness move only at the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_r  <= ZERO_C;
         digit_idx_r <= 3'd0;
         bright_q_r  <= 4'd0;
      end else if (at_wrap_s) begin
         slot_cnt_r  <= ZERO_C;
         digit_idx_r <= next_idx_s;
         bright_q_r  <= bright;
      end else begin
         slot_cnt_r  <= slot_cnt_r + ONE_C;
         digit_idx_r <= digit_idx_r;
         bright_q_r  <= bright_q_r;
      end
   end

   // Registered pin drive and frame tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r         <= 8'hFF;
         sseg_r       <= 8'hFF;
         frame_tick_r <= 1'b0;
      end else begin
         an_r         <= an_next_s;
         sseg_r       <= sseg_next_s;
         frame_tick_r <= tick_s;
      end
   end

   assign an         = an_r;
   assign sseg       = sseg_r;
   assign digit_idx  = digit_idx_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with PRESCALE=36, BLANK=4 (STEP=2).
// A cycle-level behavioural model predicts an/sseg/digit_idx/frame_tick and is
// compared every falling edge; directed checks pin absolute timings.

module tb_display_scan_ctrl;

   localparam int P  = 36;
   localparam int BL = 4;
   localparam int ST = (P - BL) / 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] seg_in;
   logic [7:0]  digit_en;
   logic [3:0]  bright;
   logic [7:0]  an;
   logic [7:0]  sseg;
   logic [2:0]  digit_idx;
   logic        frame_tick;

   int tests = 0;
   int fails = 0;
   logic chk_on = 1'b0;

   display_scan_ctrl #(.PRESCALE(P), .BLANK(BL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .digit_en   (digit_en),
      .bright     (bright),
      .an         (an),
      .sseg       (sseg),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int         m_cyc;   // cycles since the slot sequence started
   int         m_idx;
   int         m_bq;
   logic [7:0] exp_an;
   logic [7:0] exp_sseg;
   logic       exp_ft;

   function automatic int next_digit(input int idx, input logic [7:0] en);
      for (int k = 1; k <= 8; k++) begin
         if (en[(idx + k) % 8]) return (idx + k) % 8;
      end
      return idx;
   endfunction

   function automatic bit lit(input int pos, input int bq);
      return (pos >= BL) && (((pos - BL) / ST) <= bq);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc    <= 0;
         m_idx    <= 0;
         m_bq     <= 0;
         exp_an   <= 8'hFF;
         exp_sseg <= 8'hFF;
         exp_ft   <= 1'b0;
      end else begin
         if (lit(m_cyc % P, m_bq) && digit_en[m_idx]) begin
            exp_an   <= ~(8'h01 << m_idx);
            exp_sseg <= seg_in[m_idx*8 +: 8];
         end else begin
            exp_an   <= 8'hFF;
            exp_sseg <= 8'hFF;
         end
         if ((m_cyc % P) == P - 1) begin
            m_idx  <= next_digit(m_idx, digit_en);
            m_bq   <= int'(bright);
            exp_ft <= (digit_en != 8'h00) && (next_digit(m_idx, digit_en) <= m_idx);
         end else begin
            exp_ft <= 1'b0;
         end
         m_cyc <= m_cyc + 1;
      end
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Continuous compare against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check8("model_an", an, exp_an);
         check8("model_sseg", sseg, exp_sseg);
         check8("model_idx", {5'b0, digit_idx}, 8'(m_idx));
         check8("model_tick", {7'b0, frame_tick}, {7'b0, exp_ft});
      end
   end

   // Tally of cycles showing digit 1 lit.
   int fd_cnt = 0;
   always @(negedge clk) begin
      if (an == 8'hFD) fd_cnt <= fd_cnt + 1;
   end

   // ---------------- directed helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edges until frame_tick is seen; a missing tick is reported as a failure.
   task automatic wait_ft(input int max, output int n);
      n = 0;
      while (1) begin
         @(posedge clk); #1;
         n++;
         if (frame_tick) break;
         if (n >= max) begin
            check_int("ft_timeout", n, -1);
            break;
         end
      end
   endtask

   // Lit cycles over one slot, optionally changing bright partway through.
   task automatic count_on(input int change_at, input logic [3:0] nb, output int cnt);
      cnt = 0;
      for (int i = 1; i <= P; i++) begin
         @(posedge clk); #1;
         if (an != 8'hFF) cnt++;
         if (i == change_at) bright = nb;
      end
   endtask

   int n;
   int fd0;
   logic [7:0] seg0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      digit_en = 8'hFF;
      bright   = 4'd15;
      seg_in   = 64'hC0F9_A4B0_9992_82F8;
      @(posedge clk);
      chk_on = 1'b1;
      step(2);
      check8("reset_an", an, 8'hFF);
      check8("reset_sseg", sseg, 8'hFF);
      check8("reset_tick", {7'b0, frame_tick}, 8'h00);

      // 1. reset release and full-mask scan
      @(negedge clk); rst_n = 1'b1;
      step(4);
      check8("blank_edge4", an, 8'hFF);
      step(1);
      seg0 = seg_in[7:0];
      check8("first_on_an", an, 8'hFE);
      check8("first_on_sseg", sseg, seg0);
      step(30);
      check8("idx_edge35", {5'b0, digit_idx}, 8'd0);
      step(1);
      check8("idx_edge36", {5'b0, digit_idx}, 8'd1);
      wait_ft(400, n);
      check_int("first_tick_edge", n, 252);
      wait_ft(400, n);
      check_int("tick_period_ff", n, 288);

      // 2. skip mask 1000_0101
      digit_en = 8'b1000_0101;
      fd0 = fd_cnt;
      check8("skip_idx0", {5'b0, digit_idx}, 8'd0);
      step(36);
      check8("skip_idx2", {5'b0, digit_idx}, 8'd2);
      step(36);
      check8("skip_idx7", {5'b0, digit_idx}, 8'd7);
      step(36);
      check8("skip_idx0b", {5'b0, digit_idx}, 8'd0);
      check8("skip_tick", {7'b0, frame_tick}, 8'h01);
      wait_ft(400, n);
      check_int("tick_period_85", n, 108);
      check_int("never_fd", fd_cnt - fd0, 0);

      // 3. brightness
      bright = 4'd0;
      wait_ft(400, n);
      check_int("tick_period_b0", n, 108);
      count_on(-1, 4'd0, n);
      check_int("on_b0", n, 2);
      bright = 4'd7;
      count_on(-1, 4'd7, n);
      check_int("on_b0_latched", n, 2);
      count_on(10, 4'd15, n);
      check_int("on_b7_midchange", n, 16);
      count_on(-1, 4'd15, n);
      check_int("on_b15", n, 32);

      // 4. degenerate masks
      digit_en = 8'h00;
      n = 0;
      fd0 = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (an != 8'hFF) n++;
         if (frame_tick) fd0++;
      end
      check_int("en0_an_lit", n, 0);
      check_int("en0_ticks", fd0, 0);
      check8("en0_idx", {5'b0, digit_idx}, 8'd2);
      digit_en = 8'h10;
      wait_ft(400, n);
      check_int("en10_first_tick", n, 44);
      check8("en10_idx", {5'b0, digit_idx}, 8'd4);
      wait_ft(400, n);
      check_int("en10_period", n, 36);

      // 5. mid-slot disable, then async reset mid-ON
      step(10);
      check8("d4_on", an, 8'hEF);
      digit_en = 8'h00;
      step(1);
      check8("disable_blank", an, 8'hFF);
      digit_en = 8'hFF;
      wait_ft(400, n);
      check_int("reenable_tick", n, 133);
      step(10);
      check8("d0_on", an, 8'hFE);
      #2 rst_n = 1'b0;
      #1;
      check8("async_an", an, 8'hFF);
      check8("async_sseg", sseg, 8'hFF);
      check8("async_idx", {5'b0, digit_idx}, 8'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      step(4);
      check8("restart_blank", an, 8'hFF);
      step(1);
      check8("restart_on", an, 8'hFE);

      // 6. live segment data
      check8("live_before", sseg, seg0);
      seg_in[7:0] = 8'h5A;
      step(1);
      check8("live_after", sseg, 8'h5A);
      step(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
